// File: rtl/imm_pkg.sv
// Shared definitions for the 32->16 immediate narrowing stage; widths match
// the 16->32 zero-extension stage it mirrors.
package imm_pkg;

  localparam int HALF_W = 16;
  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    LO,
    HI
  } narrow_state_t;

endpackage

// File: rtl/imm_narrower_if.sv
// Word-in / halfword-out handshake bundle for the immediate narrower.
// master = producer/consumer side, slave = the narrower itself.
interface imm_narrower_if #(
  parameter int WORD_W = imm_pkg::WORD_W,
  parameter int HALF_W = imm_pkg::HALF_W
);

  logic              in_valid;
  logic              in_ready;
  logic [WORD_W-1:0] in_word;
  logic              in_force2;
  logic              out_valid;
  logic              out_ready;
  logic [HALF_W-1:0] out_half;
  logic              out_short;
  logic              out_last;

  modport master (
    output in_valid, in_word, in_force2, out_ready,
    input  in_ready, out_valid, out_half, out_short, out_last
  );

  modport slave (
    input  in_valid, in_word, in_force2, out_ready,
    output in_ready, out_valid, out_half, out_short, out_last
  );

endinterface

// File: rtl/imm_narrower.sv
// Splits 32-bit words into 16-bit beats: a word with a zero upper half goes out
// as one "short" beat, anything else as two beats, low half first.
module imm_narrower #(
  parameter int WORD_W = imm_pkg::WORD_W,
  parameter int HALF_W = imm_pkg::HALF_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  imm_narrower_if.slave        bus,
  output logic [15:0]          cnt_short,
  output logic [15:0]          cnt_long
);

  import imm_pkg::*;

  narrow_state_t     state;
  narrow_state_t     state_nxt;
  logic [WORD_W-1:0] hold;
  logic              short_q;
  logic              last_beat;
  logic              fire;
  logic              accept;

  // The ready path looks only at state and out_ready, so chained stages
  // can refill on the same edge that retires the final beat.
  assign last_beat    = ((state == LO) && short_q) || (state == HI);
  assign fire         = (state != IDLE) && bus.out_ready;
  assign bus.in_ready = (state == IDLE) || (bus.out_ready && last_beat);
  assign accept       = bus.in_valid && bus.in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) state_nxt = LO;
      end
      LO: begin
        if (bus.out_ready) begin
          if (!short_q)    state_nxt = HI;
          else if (accept) state_nxt = LO;
          else             state_nxt = IDLE;
        end
      end
      HI: begin
        if (bus.out_ready) state_nxt = accept ? LO : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.out_valid = 1'b0;
    bus.out_half  = '0;
    bus.out_short = 1'b0;
    bus.out_last  = 1'b0;
    case (state)
      LO: begin
        bus.out_valid = 1'b1;
        bus.out_half  = hold[HALF_W-1:0];
        bus.out_short = short_q;
        bus.out_last  = short_q;
      end
      HI: begin
        bus.out_valid = 1'b1;
        bus.out_half  = hold[WORD_W-1:HALF_W];
        bus.out_last  = 1'b1;
      end
      default: ;
    endcase
  end

  // accept can only fire when the current word is retiring, so hold and
  // short_q stay put under back-pressure without an extra enable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold    <= '0;
      short_q <= 1'b0;
    end else if (accept) begin
      hold    <= bus.in_word;
      short_q <= (bus.in_word[WORD_W-1:HALF_W] == '0) && !bus.in_force2;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_short <= '0;
    end else if (fire && (state == LO) && short_q) begin
      cnt_short <= cnt_short + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_long <= '0;
    end else if (fire && (state == HI)) begin
      cnt_long <= cnt_long + 16'd1;
    end
  end

endmodule

// File: tb/tb_imm_narrower.sv
// Scoreboard bench for imm_narrower: accepted words are expanded into expected
// beats by a word-level model; a negedge monitor retires and compares them.
module tb_imm_narrower;

  typedef struct {
    logic [15:0] half;
    logic        is_short;
    logic        last;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] cnt_short;
  logic [15:0] cnt_long;

  beat_t       exp_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [15:0] exp_short = '0;
  logic [15:0] exp_long = '0;
  int          ready_mode = 2;
  bit          mon_en = 1'b0;

  imm_narrower_if #(.WORD_W(32), .HALF_W(16)) bus ();

  imm_narrower #(.WORD_W(32), .HALF_W(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .cnt_short (cnt_short),
    .cnt_long  (cnt_long)
  );

  initial forever #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  // Word-level reference: a zero upper half without force2 is one short beat,
  // otherwise low half then high half.
  task automatic modelWord(input logic [31:0] w, input logic f2);
    beat_t b;
    if (w[31:16] == 16'h0000 && !f2) begin
      b.half = w[15:0]; b.is_short = 1'b1; b.last = 1'b1;
      exp_q.push_back(b);
    end else begin
      b.half = w[15:0];  b.is_short = 1'b0; b.last = 1'b0;
      exp_q.push_back(b);
      b.half = w[31:16]; b.is_short = 1'b0; b.last = 1'b1;
      exp_q.push_back(b);
    end
  endtask

  // Called just after a rising edge; returns just after the edge that took the word.
  task automatic applyStimulus(input logic [31:0] w, input logic f2, output int waits);
    bit taken = 1'b0;
    waits = 0;
    bus.in_valid  = 1'b1;
    bus.in_word   = w;
    bus.in_force2 = f2;
    while (!taken && waits < 50) begin
      @(negedge clk);
      #1;
      if (bus.in_ready) begin
        modelWord(w, f2);
        taken = 1'b1;
      end else begin
        waits++;
      end
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    if (!taken) begin
      checks++;
      errors++;
      $display("[TB] FAIL accept_timeout: word %h not accepted after %0d cycles", w, waits);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (ready_mode == 0)      bus.out_ready = 1'b1;
      else if (ready_mode == 1) bus.out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  always @(negedge clk) begin
    if (rst_n && mon_en) begin
      checkOutput("cnt_short", {16'h0, cnt_short}, {16'h0, exp_short});
      checkOutput("cnt_long", {16'h0, cnt_long}, {16'h0, exp_long});
      checkOutput("out_valid", {31'h0, bus.out_valid}, {31'h0, exp_q.size() != 0});
      checkOutput("in_ready", {31'h0, bus.in_ready},
                  {31'h0, (exp_q.size() == 0) || (bus.out_ready && exp_q[0].last)});
      if (bus.out_valid && exp_q.size() != 0) begin
        checkOutput("beat_half", {16'h0, bus.out_half}, {16'h0, exp_q[0].half});
        checkOutput("beat_short", {31'h0, bus.out_short}, {31'h0, exp_q[0].is_short});
        checkOutput("beat_last", {31'h0, bus.out_last}, {31'h0, exp_q[0].last});
        if (bus.out_ready) begin
          if (exp_q[0].is_short)  exp_short = exp_short + 16'd1;
          else if (exp_q[0].last) exp_long  = exp_long + 16'd1;
          void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    int          w1, w2, w3;
    logic [31:0] r;
    logic [31:0] w;
    logic        f;

    bus.in_valid  = 1'b0;
    bus.in_word   = '0;
    bus.in_force2 = 1'b0;
    bus.out_ready = 1'b0;

    #12;
    checkOutput("rst_out_valid", {31'h0, bus.out_valid}, 32'h0);
    checkOutput("rst_out_half", {16'h0, bus.out_half}, 32'h0);
    checkOutput("rst_out_short", {31'h0, bus.out_short}, 32'h0);
    checkOutput("rst_out_last", {31'h0, bus.out_last}, 32'h0);
    checkOutput("rst_in_ready", {31'h0, bus.in_ready}, 32'h1);
    checkOutput("rst_cnt_short", {16'h0, cnt_short}, 32'h0);
    checkOutput("rst_cnt_long", {16'h0, cnt_long}, 32'h0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    ready_mode    = 0;
    bus.out_ready = 1'b1;
    mon_en        = 1'b1;

    $display("[TB] short word");
    applyStimulus(32'h0000_1234, 1'b0, w1);
    checkOutput("t1_half", {16'h0, bus.out_half}, 32'h1234);
    checkOutput("t1_short", {31'h0, bus.out_short}, 32'h1);
    checkOutput("t1_last", {31'h0, bus.out_last}, 32'h1);
    @(posedge clk);
    #1;
    checkOutput("t1_cnt_short", {16'h0, cnt_short}, 32'h1);

    $display("[TB] long word");
    applyStimulus(32'hABCD_5678, 1'b0, w1);
    checkOutput("t2_lo_half", {16'h0, bus.out_half}, 32'h5678);
    checkOutput("t2_lo_short", {31'h0, bus.out_short}, 32'h0);
    checkOutput("t2_lo_last", {31'h0, bus.out_last}, 32'h0);
    checkOutput("t2_lo_in_ready", {31'h0, bus.in_ready}, 32'h0);
    @(posedge clk);
    #1;
    checkOutput("t2_hi_half", {16'h0, bus.out_half}, 32'hABCD);
    checkOutput("t2_hi_last", {31'h0, bus.out_last}, 32'h1);
    @(posedge clk);
    #1;
    checkOutput("t2_cnt_long", {16'h0, cnt_long}, 32'h1);

    $display("[TB] forced two-beat word");
    applyStimulus(32'h0000_0042, 1'b1, w1);
    checkOutput("t3_lo_half", {16'h0, bus.out_half}, 32'h0042);
    checkOutput("t3_lo_short", {31'h0, bus.out_short}, 32'h0);
    @(posedge clk);
    #1;
    checkOutput("t3_hi_half", {16'h0, bus.out_half}, 32'h0000);
    checkOutput("t3_hi_short", {31'h0, bus.out_short}, 32'h0);
    @(posedge clk);
    #1;

    $display("[TB] back-to-back stream");
    applyStimulus(32'h0000_0001, 1'b0, w1);
    applyStimulus(32'h0000_0002, 1'b0, w2);
    applyStimulus(32'hFFFF_0003, 1'b0, w3);
    checkOutput("t4_stall_w2", w2, 32'h0);
    checkOutput("t4_stall_w3", w3, 32'h0);
    repeat (3) begin
      @(posedge clk);
      #1;
    end

    $display("[TB] back-pressure on high beat");
    ready_mode    = 2;
    bus.out_ready = 1'b1;
    applyStimulus(32'h1111_2222, 1'b0, w1);
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    repeat (5) begin
      @(posedge clk);
      #1;
      checkOutput("t5_bp_half", {16'h0, bus.out_half}, 32'h1111);
      checkOutput("t5_bp_valid", {31'h0, bus.out_valid}, 32'h1);
      checkOutput("t5_bp_in_ready", {31'h0, bus.in_ready}, 32'h0);
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("t5_done_valid", {31'h0, bus.out_valid}, 32'h0);
    ready_mode = 0;

    $display("[TB] reset mid-word");
    applyStimulus(32'hDEAD_BEEF, 1'b0, w1);
    mon_en = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("t6_rst_valid", {31'h0, bus.out_valid}, 32'h0);
    checkOutput("t6_rst_half", {16'h0, bus.out_half}, 32'h0);
    checkOutput("t6_rst_cnt_short", {16'h0, cnt_short}, 32'h0);
    checkOutput("t6_rst_cnt_long", {16'h0, cnt_long}, 32'h0);
    checkOutput("t6_rst_in_ready", {31'h0, bus.in_ready}, 32'h1);
    exp_q.delete();
    exp_short = '0;
    exp_long  = '0;
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("t6_no_hi_beat", {31'h0, bus.out_valid}, 32'h0);
    mon_en = 1'b1;

    $display("[TB] random traffic");
    ready_mode = 1;
    for (int i = 0; i < 300; i++) begin
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
      r = $urandom();
      case ($urandom_range(0, 3))
        0:       w = {16'h0000, r[15:0]};
        1:       w = 32'h0000_0000;
        default: w = r;
      endcase
      f = ($urandom_range(0, 3) == 0);
      applyStimulus(w, f, w1);
    end

    ready_mode = 0;
    for (int i = 0; i < 200 && (exp_q.size() != 0 || bus.out_valid); i++) begin
      @(posedge clk);
      #1;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL drain: %0d beats still expected, got none", exp_q.size());
    end
    @(negedge clk);
    #1;

    $display("== %0d vectors applied, %0d miscompares ==", checks, errors);
    $finish;
  end

endmodule

// File: doc/imm_narrower.md
# imm_narrower

Narrows 32-bit words into 16-bit halfword beats for the 16-bit immediate path; it is the inverse of the 16→32 zero-extension stage. A word whose upper half is zero goes out as a single "short" beat, which the consumer re-extends by zero-filling. Any other word goes out as two beats, low half first. It sits between the 32-bit result/constant producer and the 16-bit immediate/instruction-field consumer, with valid/ready handshakes on both sides.

## Interface
Parameters:
- WORD_W, 32, input word width; must equal 2*HALF_W
- HALF_W, 16, output beat width

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  producer offers in_word
- in_ready  out  1  block accepts in_word this cycle
- in_word  in  WORD_W  word to narrow
- in_force2  in  1  sampled with in_word; 1 = always emit two beats, even when the upper half is zero
- out_valid  out  1  out_half is valid
- out_ready  in  1  consumer takes the beat
- out_half  out  HALF_W  current halfword beat
- out_short  out  1  1 = single-beat word; the consumer zero-extends it
- out_last  out  1  final beat of the current word
- cnt_short  out  16  number of short words emitted; wraps at 0xFFFF→0
- cnt_long  out  16  number of two-beat words emitted; wraps

## Operation
- Holding register `hold` (WORD_W) and flag `short_q`, captured on in_valid && in_ready.
- short_q = (in_word[WORD_W-1:HALF_W] == 0) && !in_force2.
- FSM states:
  - IDLE: nothing held.
  - LO: presenting the low half.
  - HI: presenting the high half.
- FSM transitions:
  - IDLE → LO on accept.
  - LO, out_ready, short_q=1: → LO on a new accept, else → IDLE.
  - LO, out_ready, short_q=0: → HI.
  - HI, out_ready: → LO on a new accept, else → IDLE.
  - No out_ready: hold the current state.
- Output decode:
  - out_valid = (state != IDLE).
  - out_half = hold[HALF_W-1:0] in LO, hold[WORD_W-1:HALF_W] in HI.
  - out_short = short_q in LO, 0 in HI.
  - out_last = (LO && short_q) || HI.
- in_ready = (state == IDLE) || (out_valid && out_ready && out_last). This is combinational from out_ready, so the block can be chained at full rate.
- Counters:
  - cnt_short increments on a handshake of an LO beat with short_q=1.
  - cnt_long increments on a handshake of an HI beat.
  - Both counters wrap silently.
- Held data, short_q and state never change while out_valid && !out_ready (back-pressure stability).
- in_word value 0x0000_0000 is short: one beat, out_half = 0x0000.

## Timing
- Reset (asynchronous assert, synchronous deassert handled upstream) forces:
  - state = IDLE, hold = 0, short_q = 0.
  - out_valid = 0, out_half = 0, out_short = 0, out_last = 0.
  - cnt_short = 0, cnt_long = 0, in_ready = 1.
- Reset mid-word drops the held word; no partial second beat is emitted after reset.
- Latency: a word accepted at edge N presents its first beat in the cycle after edge N, with no combinational in→out path.
- Throughput with out_ready held high:
  - short words: 1 word per cycle.
  - long words: 1 word per 2 cycles; in_ready is low during the LO beat of a long word.
- Simultaneous last-beat handshake and new accept in the same cycle: the new word is captured, state goes to LO, and there are no bubbles.
- An in_valid drop without acceptance is legal. in_word may change while in_valid && !in_ready.

## Structure
- Shared package `imm_pkg`:
  - `narrow_state_t` enum {IDLE, LO, HI}.
  - constants HALF_W=16 and WORD_W=32, matching the extension stage.
- Single module, no sub-modules. The counters are inline always_ff blocks.

## Test plan
- Reset release, then in_word=0x0000_1234, out_ready=1 → next cycle out_half=0x1234, out_short=1, out_last=1; cnt_short=1 after the handshake.
- in_word=0xABCD_5678 → beat 1 out_half=0x5678, short=0, last=0; beat 2 out_half=0xABCD, last=1; in_ready=0 during beat 1; cnt_long=1.
- in_word=0x0000_0042 with in_force2=1 → two beats, 0x0042 then 0x0000, out_short=0.
- Back-to-back stream 0x1, 0x2, 0xFFFF_0003 with out_ready=1 → beats 0x0001, 0x0002, 0x0003, 0xFFFF on consecutive cycles with no bubbles.
- out_ready held low for 5 cycles during the HI beat of 0x1111_2222 → out_half stays 0x1111, out_valid stays 1, in_ready=0; release → completes with a single HI handshake.
- rst_n pulsed low during the LO beat of 0xDEAD_BEEF → out_valid=0 immediately, no 0xDEAD beat afterward, counters = 0.
